// File: rtl/llc_set_engine.sv
// Last-level-cache tag/MESI/pseudo-LRU engine: one request at a time through
// LOOKUP then UPDATE, plus a set-by-set CLEAR walk.
module llc_set_engine #(
    parameter int ADDR_BITS   = 32,
    parameter int OFFSET_BITS = 6,
    parameter int SETS        = 64,
    parameter int WAYS        = 16,
    localparam int INDEX_BITS = $clog2(SETS),
    localparam int WAY_BITS   = $clog2(WAYS),
    localparam int PLRU_BITS  = WAYS - 1,
    localparam int TAG_BITS   = ADDR_BITS - OFFSET_BITS - INDEX_BITS,
    localparam int LINE_BITS  = ADDR_BITS - OFFSET_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [3:0]           req_op_i,
    input  logic [ADDR_BITS-1:0] req_addr_i,
    input  logic [1:0]           req_snoop_i,
    output logic                 rsp_valid_o,
    output logic                 rsp_hit_o,
    output logic [WAY_BITS-1:0]  rsp_way_o,
    output logic [1:0]           rsp_mesi_o,
    output logic [2:0]           rsp_bus_op_o,
    output logic                 rsp_wb_o,
    output logic                 rsp_evict_o,
    output logic [2:0]           rsp_l1_msg_o,
    output logic [1:0]           rsp_snoop_out_o
);

    localparam logic [1:0] MESI_I = 2'b00;
    localparam logic [1:0] MESI_E = 2'b01;
    localparam logic [1:0] MESI_M = 2'b10;
    localparam logic [1:0] MESI_S = 2'b11;

    localparam logic [3:0] OP_RD    = 4'd0;
    localparam logic [3:0] OP_WR    = 4'd1;
    localparam logic [3:0] OP_IRD   = 4'd2;
    localparam logic [3:0] OP_SRD   = 4'd3;
    localparam logic [3:0] OP_SRWIM = 4'd5;
    localparam logic [3:0] OP_SINV  = 4'd6;
    localparam logic [3:0] OP_CLR   = 4'd8;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_READ = 3'd1;
    localparam logic [2:0] BUS_INV  = 3'd3;
    localparam logic [2:0] BUS_RWIM = 3'd4;

    localparam logic [2:0] L1_NONE = 3'd0;
    localparam logic [2:0] L1_GET  = 3'd1;
    localparam logic [2:0] L1_SEND = 3'd2;
    localparam logic [2:0] L1_INVL = 3'd3;

    localparam logic [1:0] SNP_HIT   = 2'b00;
    localparam logic [1:0] SNP_HITM  = 2'b01;
    localparam logic [1:0] SNP_NOHIT = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_UPDATE, ST_CLEAR} state_t;

    state_t state_q, state_d;

    logic [3:0]            op_q;
    logic [LINE_BITS-1:0]  line_q;
    logic                  snoop_nohit_q;
    logic [INDEX_BITS-1:0] clr_idx_q;

    logic                  hit_q;
    logic [WAY_BITS-1:0]   hit_way_q, victim_q;
    logic [1:0]            hit_mesi_q, vic_mesi_q;

    logic [SETS-1:0][WAYS-1:0][1:0]    mesi_q;
    logic [SETS-1:0][PLRU_BITS-1:0]    plru_q;
    logic [TAG_BITS-1:0]               tag_mem [SETS][WAYS];

    logic                  rsp_valid_q, rsp_hit_q, rsp_wb_q, rsp_evict_q;
    logic [WAY_BITS-1:0]   rsp_way_q;
    logic [1:0]            rsp_mesi_q, rsp_snoop_out_q;
    logic [2:0]            rsp_bus_op_q, rsp_l1_msg_q;

    // Offset bits and the HIT/HITM distinction on our own bus op never matter here.
    logic unused_inputs;
    assign unused_inputs = ^{req_addr_i[OFFSET_BITS-1:0], req_snoop_i[0]};

    logic                  accept;
    logic                  clr_last;
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   line_tag;

    assign accept   = req_valid_i && (state_q == ST_IDLE);
    assign clr_last = (clr_idx_q == INDEX_BITS'(SETS - 1));
    assign idx      = line_q[INDEX_BITS-1:0];
    assign line_tag = line_q[LINE_BITS-1:INDEX_BITS];

    // Tree walk from the root; a 0 bit steers toward child 2n+1.
    function automatic logic [WAY_BITS-1:0] plru_victim(input logic [PLRU_BITS-1:0] bits);
        logic [PLRU_BITS-1:0] t;
        int node;
        node = 0;
        for (int l = 0; l < WAY_BITS; l++) begin
            t    = bits >> node;
            node = 2 * node + (t[0] ? 2 : 1);
        end
        return WAY_BITS'(node - PLRU_BITS);
    endfunction

    function automatic logic [PLRU_BITS-1:0] plru_touch(input logic [PLRU_BITS-1:0] bits,
                                                        input logic [WAY_BITS-1:0]  way);
        logic [PLRU_BITS-1:0] r, mask;
        logic [WAY_BITS-1:0]  w;
        int node;
        r    = bits;
        w    = way;
        node = 0;
        for (int l = 0; l < WAY_BITS; l++) begin
            mask = PLRU_BITS'(1) << node;
            if (w[WAY_BITS-1]) r = r & ~mask;
            else               r = r | mask;
            node = 2 * node + (w[WAY_BITS-1] ? 2 : 1);
            w    = w << 1;
        end
        return r;
    endfunction

    // ---------------- lookup ----------------
    logic [WAYS-1:0][1:0]  set_mesi;
    logic [PLRU_BITS-1:0]  set_plru;
    logic [WAYS-1:0]       way_valid, way_match;
    logic                  lk_hit, found_m, found_i;
    logic [WAY_BITS-1:0]   lk_hit_way, lk_victim;

    assign set_mesi = mesi_q[idx];
    assign set_plru = plru_q[idx];

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            assign way_valid[gi] = (set_mesi[gi] != MESI_I);
            assign way_match[gi] = way_valid[gi] && (tag_mem[idx][gi] == line_tag);
        end
    endgenerate

    always_comb begin
        lk_hit     = |way_match;
        lk_hit_way = '0;
        lk_victim  = plru_victim(set_plru);
        found_m    = 1'b0;
        found_i    = 1'b0;
        for (logic [WAY_BITS:0] w = '0; w < (WAY_BITS+1)'(WAYS); w++) begin
            if (way_match[w[WAY_BITS-1:0]] && !found_m) begin
                lk_hit_way = w[WAY_BITS-1:0];
                found_m    = 1'b1;
            end
            if (!way_valid[w[WAY_BITS-1:0]] && !found_i) begin
                lk_victim = w[WAY_BITS-1:0];
                found_i   = 1'b1;
            end
        end
    end

    // ---------------- update decode ----------------
    logic [WAY_BITS-1:0] upd_way, rsp_way_d;
    logic [1:0]          new_mesi_d, snoop_out_d;
    logic [2:0]          bus_op_d, l1_msg_d;
    logic                wb_d, evict_d, mesi_we_d, tag_we_d, plru_we_d;

    assign upd_way = hit_q ? hit_way_q : victim_q;

    always_comb begin
        new_mesi_d  = hit_q ? hit_mesi_q : MESI_I;
        rsp_way_d   = hit_q ? hit_way_q : '0;
        bus_op_d    = BUS_NONE;
        l1_msg_d    = L1_NONE;
        snoop_out_d = SNP_NOHIT;
        wb_d        = 1'b0;
        evict_d     = 1'b0;
        mesi_we_d   = 1'b0;
        tag_we_d    = 1'b0;
        plru_we_d   = 1'b0;
        case (op_q)
            OP_RD, OP_IRD: begin
                rsp_way_d = upd_way;
                l1_msg_d  = L1_SEND;
                plru_we_d = 1'b1;
                if (!hit_q) begin
                    bus_op_d   = BUS_READ;
                    new_mesi_d = snoop_nohit_q ? MESI_E : MESI_S;
                    mesi_we_d  = 1'b1;
                    tag_we_d   = 1'b1;
                    wb_d       = (vic_mesi_q == MESI_M);
                    evict_d    = (vic_mesi_q != MESI_I);
                end
            end
            OP_WR: begin
                rsp_way_d  = upd_way;
                l1_msg_d   = L1_SEND;
                plru_we_d  = 1'b1;
                new_mesi_d = MESI_M;
                mesi_we_d  = 1'b1;
                if (hit_q) begin
                    if (hit_mesi_q == MESI_S) bus_op_d = BUS_INV;
                end else begin
                    bus_op_d = BUS_RWIM;
                    tag_we_d = 1'b1;
                    wb_d     = (vic_mesi_q == MESI_M);
                    evict_d  = (vic_mesi_q != MESI_I);
                end
            end
            OP_SRD: begin
                if (hit_q) begin
                    new_mesi_d = MESI_S;
                    mesi_we_d  = 1'b1;
                    if (hit_mesi_q == MESI_M) begin
                        snoop_out_d = SNP_HITM;
                        wb_d        = 1'b1;
                        l1_msg_d    = L1_GET;
                    end else begin
                        snoop_out_d = SNP_HIT;
                    end
                end
            end
            OP_SRWIM: begin
                if (hit_q) begin
                    new_mesi_d = MESI_I;
                    mesi_we_d  = 1'b1;
                    if (hit_mesi_q == MESI_M) begin
                        snoop_out_d = SNP_HITM;
                        wb_d        = 1'b1;
                        l1_msg_d    = L1_GET;
                    end else begin
                        snoop_out_d = SNP_HIT;
                        l1_msg_d    = L1_INVL;
                    end
                end
            end
            OP_SINV: begin
                if (hit_q && hit_mesi_q == MESI_S) begin
                    new_mesi_d  = MESI_I;
                    mesi_we_d   = 1'b1;
                    snoop_out_d = SNP_HIT;
                    l1_msg_d    = L1_INVL;
                end
            end
            default: ;
        endcase
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_valid_i) state_d = (req_op_i == OP_CLR) ? ST_CLEAR : ST_LOOKUP;
            ST_LOOKUP: state_d = ST_UPDATE;
            ST_UPDATE: state_d = ST_IDLE;
            ST_CLEAR:  if (clr_last) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            line_q        <= '0;
            snoop_nohit_q <= 1'b0;
            clr_idx_q     <= '0;
            hit_q         <= 1'b0;
            hit_way_q     <= '0;
            victim_q      <= '0;
            hit_mesi_q    <= MESI_I;
            vic_mesi_q    <= MESI_I;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q          <= req_op_i;
                line_q        <= req_addr_i[ADDR_BITS-1:OFFSET_BITS];
                snoop_nohit_q <= req_snoop_i[1];
                clr_idx_q     <= '0;
            end
            if (state_q == ST_CLEAR) clr_idx_q <= clr_idx_q + 1'b1;
            if (state_q == ST_LOOKUP) begin
                hit_q      <= lk_hit;
                hit_way_q  <= lk_hit_way;
                victim_q   <= lk_victim;
                hit_mesi_q <= set_mesi[lk_hit_way];
                vic_mesi_q <= set_mesi[lk_victim];
            end
        end
    end

    // ---------------- storage ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mesi_q <= '0;
            plru_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            mesi_q[clr_idx_q] <= '0;
            plru_q[clr_idx_q] <= '0;
        end else if (state_q == ST_UPDATE) begin
            if (mesi_we_d) mesi_q[idx][upd_way] <= new_mesi_d;
            if (plru_we_d) plru_q[idx] <= plru_touch(set_plru, upd_way);
        end
    end

    // Tags are qualified by MESI state, so they need no reset.
    always_ff @(posedge clk) begin
        if (state_q == ST_UPDATE && tag_we_d) tag_mem[idx][upd_way] <= line_tag;
    end

    // ---------------- response ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q     <= 1'b0;
            rsp_hit_q       <= 1'b0;
            rsp_way_q       <= '0;
            rsp_mesi_q      <= '0;
            rsp_bus_op_q    <= '0;
            rsp_wb_q        <= 1'b0;
            rsp_evict_q     <= 1'b0;
            rsp_l1_msg_q    <= '0;
            rsp_snoop_out_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (state_q == ST_UPDATE) begin
                rsp_valid_q     <= 1'b1;
                rsp_hit_q       <= hit_q;
                rsp_way_q       <= rsp_way_d;
                rsp_mesi_q      <= new_mesi_d;
                rsp_bus_op_q    <= bus_op_d;
                rsp_wb_q        <= wb_d;
                rsp_evict_q     <= evict_d;
                rsp_l1_msg_q    <= l1_msg_d;
                rsp_snoop_out_q <= snoop_out_d;
            end else if (state_q == ST_CLEAR && clr_last) begin
                rsp_valid_q     <= 1'b1;
                rsp_hit_q       <= 1'b0;
                rsp_way_q       <= '0;
                rsp_mesi_q      <= '0;
                rsp_bus_op_q    <= '0;
                rsp_wb_q        <= 1'b0;
                rsp_evict_q     <= 1'b0;
                rsp_l1_msg_q    <= '0;
                rsp_snoop_out_q <= '0;
            end
        end
    end

    assign req_ready_o     = (state_q == ST_IDLE);
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_hit_o       = rsp_hit_q;
    assign rsp_way_o       = rsp_way_q;
    assign rsp_mesi_o      = rsp_mesi_q;
    assign rsp_bus_op_o    = rsp_bus_op_q;
    assign rsp_wb_o        = rsp_wb_q;
    assign rsp_evict_o     = rsp_evict_q;
    assign rsp_l1_msg_o    = rsp_l1_msg_q;
    assign rsp_snoop_out_o = rsp_snoop_out_q;

endmodule

// File: tb/tb_llc_set_engine.sv
// Directed bench for llc_set_engine: hand-computed responses for fills, PLRU
// eviction, MESI transitions, snoops, clear and reset during a request.
module tb_llc_set_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [3:0]  req_op_i = '0;
    logic [31:0] req_addr_i = '0;
    logic [1:0]  req_snoop_i = '0;
    logic        rsp_valid_o, rsp_hit_o, rsp_wb_o, rsp_evict_o;
    logic [3:0]  rsp_way_o;
    logic [1:0]  rsp_mesi_o, rsp_snoop_out_o;
    logic [2:0]  rsp_bus_op_o, rsp_l1_msg_o;

    llc_set_engine dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_op_i        (req_op_i),
        .req_addr_i      (req_addr_i),
        .req_snoop_i     (req_snoop_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_hit_o       (rsp_hit_o),
        .rsp_way_o       (rsp_way_o),
        .rsp_mesi_o      (rsp_mesi_o),
        .rsp_bus_op_o    (rsp_bus_op_o),
        .rsp_wb_o        (rsp_wb_o),
        .rsp_evict_o     (rsp_evict_o),
        .rsp_l1_msg_o    (rsp_l1_msg_o),
        .rsp_snoop_out_o (rsp_snoop_out_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int r_lat;
    logic r_ready_busy;
    logic [16:0] r_fields;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] cur_fields();
        return {rsp_hit_o, rsp_way_o, rsp_mesi_o, rsp_bus_op_o, rsp_wb_o,
                rsp_evict_o, rsp_l1_msg_o, rsp_snoop_out_o};
    endfunction

    // Drives one request from a falling edge and waits (bounded) for its response.
    task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [1:0] snp);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_addr_i  = addr;
        req_snoop_i = snp;
        @(posedge clk);
        @(negedge clk);
        req_valid_i  = 1'b0;
        r_lat        = 1;
        r_ready_busy = 1'b0;
        while (!rsp_valid_o && r_lat < 200) begin
            r_ready_busy = r_ready_busy | req_ready_o;
            @(negedge clk);
            r_lat++;
        end
        r_fields = cur_fields();
        $display("req op=%0d addr=%08h snoop=%b : lat=%0d hit=%0d way=%0d mesi=%b bus=%0d wb=%0d ev=%0d l1=%0d snp=%b",
                 op, addr, snp, r_lat, rsp_hit_o, rsp_way_o, rsp_mesi_o, rsp_bus_op_o,
                 rsp_wb_o, rsp_evict_o, rsp_l1_msg_o, rsp_snoop_out_o);
    endtask

    task automatic expect_rsp(input string tag, input int lat, input logic hit, input logic [3:0] way,
                              input logic [1:0] mesi, input logic [2:0] bus, input logic wb,
                              input logic ev, input logic [2:0] l1, input logic [1:0] snp);
        check({tag, "/latency"}, r_lat, lat);
        check({tag, "/ready_busy"}, {31'd0, r_ready_busy}, 32'd0);
        check({tag, "/fields"}, {15'd0, r_fields}, {15'd0, hit, way, mesi, bus, wb, ev, l1, snp});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset/ready", {31'd0, req_ready_o}, 32'd1);
        check("reset/rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("reset/fields", {15'd0, cur_fields()}, 32'd0);

        // Cold read miss then hit
        do_req(4'd0, 32'h0000_1000, 2'b11);
        expect_rsp("rd_miss", 3, 1'b0, 4'd0, 2'b01, 3'd1, 1'b0, 1'b0, 3'd2, 2'b11);
        do_req(4'd0, 32'h0000_1000, 2'b11);
        expect_rsp("rd_hit", 3, 1'b1, 4'd0, 2'b01, 3'd0, 1'b0, 1'b0, 3'd2, 2'b11);

        // Fill set 0 by write misses, then force PLRU evictions
        do_reset();
        for (int t = 1; t <= 16; t++) begin
            do_req(4'd1, t << 12, 2'b11);
            expect_rsp($sformatf("fill_way%0d", t - 1), 3, 1'b0, 4'(t - 1), 2'b10, 3'd4,
                       1'b0, 1'b0, 3'd2, 2'b11);
        end
        do_req(4'd1, 32'd17 << 12, 2'b11);
        expect_rsp("evict_way0", 3, 1'b0, 4'd0, 2'b10, 3'd4, 1'b1, 1'b1, 3'd2, 2'b11);
        do_req(4'd1, 32'd18 << 12, 2'b11);
        expect_rsp("evict_way8", 3, 1'b0, 4'd8, 2'b10, 3'd4, 1'b1, 1'b1, 3'd2, 2'b11);
        do_req(4'd1, 32'd2 << 12, 2'b11);
        expect_rsp("wr_hit_M", 3, 1'b1, 4'd1, 2'b10, 3'd0, 1'b0, 1'b0, 3'd2, 2'b11);

        // MESI transitions on set 1
        do_reset();
        do_req(4'd0, 32'h0000_2040, 2'b00);
        expect_rsp("rd_miss_S", 3, 1'b0, 4'd0, 2'b11, 3'd1, 1'b0, 1'b0, 3'd2, 2'b11);
        do_req(4'd1, 32'h0000_2040, 2'b11);
        expect_rsp("wr_hit_S_inv", 3, 1'b1, 4'd0, 2'b10, 3'd3, 1'b0, 1'b0, 3'd2, 2'b11);
        do_req(4'd3, 32'h0000_2040, 2'b11);
        expect_rsp("srd_M_hitm", 3, 1'b1, 4'd0, 2'b11, 3'd0, 1'b1, 1'b0, 3'd1, 2'b01);
        do_req(4'd6, 32'h0000_2040, 2'b11);
        expect_rsp("sinv_S", 3, 1'b1, 4'd0, 2'b00, 3'd0, 1'b0, 1'b0, 3'd3, 2'b00);
        do_req(4'd0, 32'h0000_2040, 2'b11);
        expect_rsp("rd_refill_E", 3, 1'b0, 4'd0, 2'b01, 3'd1, 1'b0, 1'b0, 3'd2, 2'b11);
        do_req(4'd4, 32'h0000_2040, 2'b11);
        expect_rsp("swr_E", 3, 1'b1, 4'd0, 2'b01, 3'd0, 1'b0, 1'b0, 3'd0, 2'b11);
        do_req(4'd6, 32'h0000_2040, 2'b11);
        expect_rsp("sinv_E", 3, 1'b1, 4'd0, 2'b01, 3'd0, 1'b0, 1'b0, 3'd0, 2'b11);
        do_req(4'd7, 32'h0000_2040, 2'b11);
        expect_rsp("noop7", 3, 1'b1, 4'd0, 2'b01, 3'd0, 1'b0, 1'b0, 3'd0, 2'b11);
        do_req(4'd5, 32'h0000_2040, 2'b11);
        expect_rsp("srwim_E", 3, 1'b1, 4'd0, 2'b00, 3'd0, 1'b0, 1'b0, 3'd3, 2'b00);
        do_req(4'd6, 32'h0000_3040, 2'b11);
        expect_rsp("sinv_miss", 3, 1'b0, 4'd0, 2'b00, 3'd0, 1'b0, 1'b0, 3'd0, 2'b11);
        do_req(4'd2, 32'h0000_2040, 2'b10);
        expect_rsp("ird_miss_E", 3, 1'b0, 4'd0, 2'b01, 3'd1, 1'b0, 1'b0, 3'd2, 2'b11);
        do_req(4'd3, 32'h0000_2040, 2'b11);
        expect_rsp("srd_E_hit", 3, 1'b1, 4'd0, 2'b11, 3'd0, 1'b0, 1'b0, 3'd0, 2'b00);
        do_req(4'd0, 32'h0000_2040, 2'b11);
        expect_rsp("rd_hit_S", 3, 1'b1, 4'd0, 2'b11, 3'd0, 1'b0, 1'b0, 3'd2, 2'b11);
        do_req(4'd1, 32'h0000_2040, 2'b11);
        expect_rsp("wr_hit_S_inv2", 3, 1'b1, 4'd0, 2'b10, 3'd3, 1'b0, 1'b0, 3'd2, 2'b11);
        do_req(4'd5, 32'h0000_2040, 2'b11);
        expect_rsp("srwim_M", 3, 1'b1, 4'd0, 2'b00, 3'd0, 1'b1, 1'b0, 3'd1, 2'b01);
        do_req(4'd0, 32'h0000_2040, 2'b01);
        expect_rsp("rd_miss_hitm_S", 3, 1'b0, 4'd0, 2'b11, 3'd1, 1'b0, 1'b0, 3'd2, 2'b11);

        // Clear walk, then the line must be gone
        do_req(4'd8, 32'h0000_0000, 2'b11);
        expect_rsp("clear", 65, 1'b0, 4'd0, 2'b00, 3'd0, 1'b0, 1'b0, 3'd0, 2'b00);
        do_req(4'd0, 32'h0000_2040, 2'b11);
        expect_rsp("rd_after_clear", 3, 1'b0, 4'd0, 2'b01, 3'd1, 1'b0, 1'b0, 3'd2, 2'b11);

        // Reset while the request sits in LOOKUP
        req_valid_i = 1'b1;
        req_op_i    = 4'd1;
        req_addr_i  = 32'h0000_2040;
        req_snoop_i = 2'b11;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        check("midrst/busy", {31'd0, req_ready_o}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst/ready_in_rst", {31'd0, req_ready_o}, 32'd1);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid_o) seen++;
        end
        $display("reset during lookup : rsp_valid pulses=%0d", seen);
        check("midrst/no_rsp", seen, 0);
        check("midrst/fields", {15'd0, cur_fields()}, 32'd0);
        do_req(4'd0, 32'h0000_2040, 2'b11);
        expect_rsp("rd_after_midrst", 3, 1'b0, 4'd0, 2'b01, 3'd1, 1'b0, 1'b0, 3'd2, 2'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/llc_set_engine.md
# llc_set_engine

Synthesizable, parametrised last-level-cache tag/state engine: per-set tag + MESI storage for WAYS ways plus tree pseudo-LRU bits, serving one trace-style request at a time. Generalises the shared MESI/bus-op/snoop/L2-to-L1 encodings into a clocked block with configurable ways, sets and address width. Sits between the trace-driven request source and the bus/L1 message loggers.

## Interface
- ADDR_BITS, 32, request address width
- OFFSET_BITS, 6, line-offset bits (64 B line)
- SETS, 64, sets; power of 2, ≥2; INDEX_BITS = log2(SETS)
- WAYS, 16, ways; power of 2, ≥2; PLRU_BITS = WAYS-1
- TAG_BITS, derived = ADDR_BITS-OFFSET_BITS-INDEX_BITS
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  engine idle, accepts request
- req_op  in  4  0 L1 data read, 1 L1 write, 2 L1 instr read, 3 snooped read, 4 snooped write, 5 snooped RWIM, 6 snooped invalidate, 8 clear; others = no-op
- req_addr  in  ADDR_BITS  byte address
- req_snoop  in  2  other caches' result for our bus op (00 HIT, 01 HITM, 1x NOHIT)
- rsp_valid  out  1  one-cycle response strobe
- rsp_hit  out  1  tag match on valid way
- rsp_way  out  log2(WAYS)  hit way, else victim way (CPU ops), else 0
- rsp_mesi  out  2  resulting state (I 00, E 01, M 10, S 11)
- rsp_bus_op  out  3  0 none, 1 READ, 2 WRITE, 3 INVALIDATE, 4 RWIM
- rsp_wb  out  1  dirty line written back
- rsp_evict  out  1  valid victim replaced (L1 EVICTLINE implied)
- rsp_l1_msg  out  3  0 none, 1 GETLINE, 2 SENDLINE, 3 INVALIDATELINE
- rsp_snoop_out  out  2  our snoop reply (HIT/HITM/NOHIT=11)

## Operation
- FSM: IDLE → LOOKUP → UPDATE → IDLE; CLEAR for op 8. req_ready = (state==IDLE).
- IDLE: on req_valid&&req_ready capture op, addr, snoop; go LOOKUP.
- LOOKUP: compare tag against all ways of indexed set; compute hit way; victim = lowest-index invalid way, else PLRU victim.
- UPDATE: write MESI/tag/PLRU; drive rsp_* with rsp_valid=1; return IDLE.
- Read (0/2) hit: state unchanged, bus none, SENDLINE. Miss: bus READ, new state E if req_snoop[1]=1 else S; SENDLINE; rsp_wb=1 if victim M; rsp_evict=1 if victim valid.
- Write hit: E/M→M bus none; S→M bus INVALIDATE; SENDLINE. Miss: bus RWIM, →M, SENDLINE, wb/evict as read miss.
- Snooped read hit: E/S→S reply HIT; M→S reply HITM, rsp_wb=1, GETLINE.
- Snooped RWIM hit: M→I HITM, wb, GETLINE; E/S→I HIT, INVALIDATELINE.
- Snooped invalidate: S→I HIT, INVALIDATELINE; E/M unchanged, NOHIT.
- Snooped write, any snoop miss, unknown op: no state change, NOHIT, all messages none.
- CPU ops reply NOHIT; snoops never touch PLRU or tags and never fill.
- PLRU: node n children 2n+1 (bit 0) / 2n+2 (bit 1); victim follows bits from root; touch (CPU hit or fill) sets path bits to point away from touched way.
- Clear: CLEAR walks sets 0..SETS-1 one per cycle zeroing MESI and PLRU; rsp_valid with all fields 0 on the last-set cycle.

## Timing
- Request accepted at edge N; rsp_valid high during cycle after edge N+2; next accept at edge N+3 earliest. Clear: rsp_valid in cycle after edge N+SETS.
- Outputs registered; rsp_* hold previous values except rsp_valid (only meaningful with rsp_valid).
- Reset (anytime, incl. mid-request or mid-CLEAR): FSM IDLE, all MESI I, all PLRU 0, all rsp_* 0, req_ready 1; in-flight request dropped, no response.
- Same-set back-to-back requests see prior UPDATE (no hazard, serial FSM).

## Test plan
- After reset, read 0x0000_1000, req_snoop=11 → miss, bus READ, rsp_mesi E, way 0, SENDLINE; repeat → hit, bus none.
- Fill WAYS+1 distinct tags in set 0 by writes → first WAYS fill ways 0..15 as M via RWIM; 17th evicts PLRU victim way 0 with rsp_wb=1, rsp_evict=1.
- Read with req_snoop=00 → S; write same line → bus INVALIDATE, M; snooped read → HITM, GETLINE, wb, S.
- Snooped RWIM on E line → I, HIT, INVALIDATELINE; snooped invalidate on miss → NOHIT, no change.
- Op 8 after fills → rsp after SETS cycles; subsequent read misses; req_ready 0 during clear.
- Assert rst in LOOKUP → no rsp_valid, all lines I, next read misses.
